// File: rtl/mem_stage.sv
// MEM pipeline stage: accepts EX results, waits for the in-order data SRAM
// response of a load/store, shapes load data (LB..LWR) and hands a
// WB-format bus to the writeback stage. After a flush, responses that still
// belong to killed requests are counted and silently dropped.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         es_req_issued,
    input  logic         es_to_ms_valid,
    input  logic [204:0] es_to_ms_bus,
    output logic         ms_allowin,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [168:0] ms_to_ws_bus,
    output logic [9:0]   stall_ms_bus,
    output logic [32:0]  forward_ms_bus
);

    logic [204:0] r_busR;
    logic         r_msValid;
    logic         r_bufValid;
    logic [31:0]  r_rdataBuf;
    logic [1:0]   r_discardCnt;

    logic         w_memReq;
    logic [2:0]   w_ldOp;
    logic [31:0]  w_rtValue;
    logic [168:0] w_wbFields;
    logic [31:0]  w_aluResult;
    logic [1:0]   w_addrLow;
    logic [3:0]   w_grWe;
    logic [4:0]   w_dest;

    logic         w_dataDeliver;
    logic         w_readyGo;
    logic         w_leave;
    logic         w_waitingReq;
    logic         w_flushLost;
    logic         w_flushIssued;
    logic         w_discardDec;
    logic [31:0]  w_data;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_loadResult;
    logic [31:0]  w_result;

    assign w_memReq    = r_busR[204];
    assign w_ldOp      = r_busR[203:201];
    assign w_rtValue   = r_busR[200:169];
    assign w_wbFields  = r_busR[168:0];
    assign w_aluResult = w_wbFields[63:32];
    assign w_addrLow   = w_aluResult[1:0];
    assign w_grWe      = w_wbFields[72:69];
    assign w_dest      = w_wbFields[68:64];

    // A response only reaches this stage once every stale response is gone
    assign w_dataDeliver = data_sram_data_ok && (r_discardCnt == 2'd0);
    assign w_readyGo     = !w_memReq || r_bufValid || w_dataDeliver;
    assign ms_allowin    = !r_msValid || (w_readyGo && ws_allowin);
    assign ms_to_ws_valid = r_msValid && w_readyGo && !flush;
    assign w_leave       = ms_to_ws_valid && ws_allowin;

    // Our own outstanding request becomes stale if flushed before its data arrives
    assign w_waitingReq  = r_msValid && w_memReq && !r_bufValid;
    assign w_flushLost   = flush && w_waitingReq && !w_dataDeliver;
    assign w_flushIssued = flush && es_req_issued;
    assign w_discardDec  = data_sram_data_ok && (r_discardCnt != 2'd0);

    // Valid bit and payload register for the instruction held in MEM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msValid <= 1'b0;
            r_busR    <= '0;
        end else begin
            if (flush) begin
                r_msValid <= 1'b0;
            end else if (ms_allowin) begin
                r_msValid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                r_busR <= es_to_ms_bus;
            end
        end
    end

    // Hold a delivered response while WB is stalled so it is not lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bufValid <= 1'b0;
            r_rdataBuf <= '0;
        end else if (flush || w_leave) begin
            r_bufValid <= 1'b0;
        end else if (w_dataDeliver && w_waitingReq) begin
            r_bufValid <= 1'b1;
            r_rdataBuf <= data_sram_rdata;
        end
    end

    // Count stale responses: add those killed by flush, drop one per data_ok
    always_ff @(posedge clk) begin
        if (reset) begin
            r_discardCnt <= 2'd0;
        end else begin
            r_discardCnt <= r_discardCnt + {1'b0, w_flushLost} + {1'b0, w_flushIssued}
                            - {1'b0, w_discardDec};
        end
    end

    // Pick byte/halfword lanes from the response word by address low bits
    always_comb begin
        w_data = r_bufValid ? r_rdataBuf : data_sram_rdata;
        w_byte = w_data[7:0];
        case (w_addrLow)
            2'd0: w_byte = w_data[7:0];
            2'd1: w_byte = w_data[15:8];
            2'd2: w_byte = w_data[23:16];
            2'd3: w_byte = w_data[31:24];
            default: w_byte = w_data[7:0];
        endcase
        w_half = w_addrLow[1] ? w_data[31:16] : w_data[15:0];
    end

    // Shape the load result, merging with rt for unaligned LWL/LWR
    always_comb begin
        w_loadResult = w_aluResult;
        case (w_ldOp)
            3'd1: w_loadResult = {{24{w_byte[7]}}, w_byte};
            3'd2: w_loadResult = {24'd0, w_byte};
            3'd3: w_loadResult = {{16{w_half[15]}}, w_half};
            3'd4: w_loadResult = {16'd0, w_half};
            3'd5: w_loadResult = w_data;
            3'd6: begin
                case (w_addrLow)
                    2'd0: w_loadResult = {w_data[7:0],  w_rtValue[23:0]};
                    2'd1: w_loadResult = {w_data[15:0], w_rtValue[15:0]};
                    2'd2: w_loadResult = {w_data[23:0], w_rtValue[7:0]};
                    default: w_loadResult = w_data;
                endcase
            end
            3'd7: begin
                case (w_addrLow)
                    2'd0: w_loadResult = w_data;
                    2'd1: w_loadResult = {w_rtValue[31:24], w_data[31:8]};
                    2'd2: w_loadResult = {w_rtValue[31:16], w_data[31:16]};
                    default: w_loadResult = {w_rtValue[31:8], w_data[31:24]};
                endcase
            end
            default: w_loadResult = w_aluResult;
        endcase
    end

    // Non-load instructions pass the ALU result through untouched
    always_comb begin
        w_result       = (w_ldOp != 3'd0) ? w_loadResult : w_aluResult;
        ms_to_ws_bus   = {w_wbFields[168:64], w_result, w_wbFields[31:0]};
        stall_ms_bus   = {r_msValid && (|w_grWe), w_grWe & {4{r_msValid}}, w_dest};
        forward_ms_bus = {r_msValid && w_readyGo, w_result};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load shaping, WB backpressure
// buffering, flush-driven response discarding, passthrough and reset.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         es_req_issued;
    logic         es_to_ms_valid;
    logic [204:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [168:0] ms_to_ws_bus;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;

    int testsRun;
    int testsFailed;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .es_req_issued     (es_req_issued),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the value is wrong
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs at the falling edge and let combinational outputs settle
    task automatic applyStimulus(input logic esValid, input logic [204:0] esBus,
                                 input logic wsAllow, input logic dataOk,
                                 input logic [31:0] rdata, input logic flushIn,
                                 input logic issued);
        es_to_ms_valid    = esValid;
        es_to_ms_bus      = esBus;
        ws_allowin        = wsAllow;
        data_sram_data_ok = dataOk;
        data_sram_rdata   = rdata;
        flush             = flushIn;
        es_req_issued     = issued;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [168:0] makeWb(input logic [3:0] grWe, input logic [4:0] dest,
                                            input logic [31:0] alu, input logic [31:0] pc);
        return {32'hA5A5_0001, 4'h3, 32'hBAD0_0000, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0,
                8'h60, grWe, dest, alu, pc};
    endfunction

    function automatic logic [204:0] makeEs(input logic memReq, input logic [2:0] ldOp,
                                            input logic [31:0] rt, input logic [168:0] wb);
        return {memReq, ldOp, rt, wb};
    endfunction

    function automatic logic [168:0] withResult(input logic [168:0] wb, input logic [31:0] res);
        return {wb[168:64], res, wb[31:0]};
    endfunction

    // Enter a load, answer it on its first MEM cycle, check the shaped result
    task automatic runLoad(input string tag, input logic [204:0] esBus,
                           input logic [31:0] rdata, input logic [31:0] expRes);
        logic [168:0] wb;
        wb = esBus[168:0];
        applyStimulus(1'b1, esBus, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, "_allowin"}, ms_allowin, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, rdata, 1'b0, 1'b0);
        checkOutput({tag, "_valid"}, ms_to_ws_valid, 1'b1);
        checkOutput({tag, "_bus"}, ms_to_ws_bus, withResult(wb, expRes));
        checkOutput({tag, "_fwd"}, forward_ms_bus, {1'b1, expRes});
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, "_gone"}, ms_to_ws_valid, 1'b0);
    endtask

    initial begin
        logic [168:0] wb;
        logic [204:0] es;
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("rst_allowin", ms_allowin, 1'b1);
        checkOutput("rst_valid", ms_to_ws_valid, 1'b0);
        checkOutput("rst_stall9", stall_ms_bus[9], 1'b0);
        checkOutput("rst_fwd32", forward_ms_bus[32], 1'b0);
        reset = 1'b0;
        nextCycle();

        // LB a=3, data_ok on entry cycle
        wb = makeWb(4'hF, 5'd8, 32'h1000_0003, 32'hBFC0_0100);
        es = makeEs(1'b1, 3'd1, 32'h0, wb);
        applyStimulus(1'b1, es, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80FF_1234, 1'b0, 1'b0);
        checkOutput("lb_valid", ms_to_ws_valid, 1'b1);
        checkOutput("lb_bus", ms_to_ws_bus, withResult(wb, 32'hFFFF_FF80));
        checkOutput("lb_stall", stall_ms_bus, {1'b1, 4'hF, 5'd8});
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("lb_gone", ms_to_ws_valid, 1'b0);
        checkOutput("lb_stall_idle", stall_ms_bus, {1'b0, 4'h0, 5'd8});

        // LW with WB stalled: response buffered and held
        wb = makeWb(4'hF, 5'd9, 32'h2000_0000, 32'hBFC0_0104);
        es = makeEs(1'b1, 3'd5, 32'h0, wb);
        applyStimulus(1'b1, es, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("lw_wait_valid", ms_to_ws_valid, 1'b0);
        checkOutput("lw_wait_allowin", ms_allowin, 1'b0);
        checkOutput("lw_wait_fwd32", forward_ms_bus[32], 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("lw_ok_valid", ms_to_ws_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h1234_5678 + i, 1'b0, 1'b0);
            checkOutput("lw_hold_res", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
            checkOutput("lw_hold_allowin", ms_allowin, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
        checkOutput("lw_rel_valid", ms_to_ws_valid, 1'b1);
        checkOutput("lw_rel_bus", ms_to_ws_bus, withResult(wb, 32'hDEAD_BEEF));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("lw_once", ms_to_ws_valid, 1'b0);

        // Partial and unaligned loads
        runLoad("lwr2", makeEs(1'b1, 3'd7, 32'h1122_3344,
                makeWb(4'hF, 5'd10, 32'h3000_0002, 32'hBFC0_0108)), 32'hAABB_CCDD, 32'h1122_AABB);
        runLoad("lwl1", makeEs(1'b1, 3'd6, 32'h1122_3344,
                makeWb(4'hF, 5'd10, 32'h3000_0001, 32'hBFC0_010C)), 32'hAABB_CCDD, 32'hCCDD_3344);
        runLoad("lh2", makeEs(1'b1, 3'd3, 32'h0,
                makeWb(4'hF, 5'd11, 32'h3000_0012, 32'hBFC0_0110)), 32'h8001_7777, 32'hFFFF_8001);
        runLoad("lhu0", makeEs(1'b1, 3'd4, 32'h0,
                makeWb(4'hF, 5'd11, 32'h3000_0010, 32'hBFC0_0114)), 32'h1234_F00F, 32'h0000_F00F);
        runLoad("lbu1", makeEs(1'b1, 3'd2, 32'h0,
                makeWb(4'hF, 5'd11, 32'h3000_0021, 32'hBFC0_0118)), 32'h0000_9A00, 32'h0000_009A);

        // Flush while LW waits plus an issued EX request: two responses dropped
        wb = makeWb(4'hF, 5'd12, 32'h4000_0000, 32'hBFC0_0200);
        applyStimulus(1'b1, makeEs(1'b1, 3'd5, 32'h0, wb), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("fl_valid", ms_to_ws_valid, 1'b0);
        nextCycle();
        wb = makeWb(4'hF, 5'd13, 32'h4000_0004, 32'hBFC0_0380);
        applyStimulus(1'b1, makeEs(1'b1, 3'd5, 32'h0, wb), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("fl_allowin", ms_allowin, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        checkOutput("fl_drop1", ms_to_ws_valid, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        checkOutput("fl_drop2", ms_to_ws_valid, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b0);
        checkOutput("fl_third_valid", ms_to_ws_valid, 1'b1);
        checkOutput("fl_third_bus", ms_to_ws_bus, withResult(wb, 32'h3333_3333));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Non-memory ALU op: one-cycle passthrough
        wb = makeWb(4'h3, 5'd14, 32'hCAFE_F00D, 32'hBFC0_0400);
        applyStimulus(1'b1, makeEs(1'b0, 3'd0, 32'h9999_9999, wb), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h7777_7777, 1'b0, 1'b0);
        checkOutput("alu_valid", ms_to_ws_valid, 1'b1);
        checkOutput("alu_bus", ms_to_ws_bus, wb);
        checkOutput("alu_fwd", forward_ms_bus, {1'b1, 32'hCAFE_F00D});
        checkOutput("alu_stall", stall_ms_bus, {1'b1, 4'h3, 5'd14});
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("alu_gone", ms_to_ws_valid, 1'b0);

        // Reset mid-wait with one stale response pending
        wb = makeWb(4'hF, 5'd15, 32'h5000_0000, 32'hBFC0_0500);
        applyStimulus(1'b1, makeEs(1'b1, 3'd5, 32'h0, wb), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, makeEs(1'b1, 3'd5, 32'h0, wb), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rw_wait_allowin", ms_allowin, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rw_allowin", ms_allowin, 1'b1);
        checkOutput("rw_valid", ms_to_ws_valid, 1'b0);
        checkOutput("rw_stall9", stall_ms_bus[9], 1'b0);
        checkOutput("rw_fwd32", forward_ms_bus[32], 1'b0);
        runLoad("rw_cnt0", makeEs(1'b1, 3'd5, 32'h0,
                makeWb(4'hF, 5'd16, 32'h5000_0008, 32'hBFC0_0504)), 32'h0BAD_F00D, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
